// File: rtl/core_bus_pkg.sv
// Shared definitions for the core memory fabric: FSM encoding, default MMIO map
// and the width helpers used when unpacking the flat per-port request buses.
package core_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bus_state_e;

  localparam logic [31:0] DEFAULT_LED_ADDR = 32'hFFFF_FF00;
  localparam int          DEFAULT_ADDR_W   = 32;
  localparam int          DEFAULT_DATA_W   = 32;

  // Index width that stays legal for a single port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner whenever a grant is taken.
module core_rr_arbiter
  import core_bus_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IW        = idx_w(NUM_PORTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_en,
  input  logic                 i_adv,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [IW-1:0]        o_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;

  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int p;
      p = (int'(r_ptr) + k) % NUM_PORTS;
      if (!w_found && i_req[p]) begin
        w_found = 1'b1;
        o_idx   = IW'(p);
      end
    end
  end

  assign o_gnt = (i_en && w_found) ? (NUM_PORTS'(1) << o_idx) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_ptr <= '0;
    else if (i_adv)
      r_ptr <= (o_idx == IW'(NUM_PORTS - 1)) ? '0 : o_idx + 1'b1;
  end

endmodule

// File: rtl/core_mem_fabric.sv
// Multi-requester front end for the core RAM: round-robin arbitration, one
// outstanding transaction, configurable RAM read latency and an MMIO LED register.
module core_mem_fabric
  import core_bus_pkg::*;
#(
  parameter int                NUM_PORTS   = 2,
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter int                DATA_W      = DEFAULT_DATA_W,
  parameter int                RAM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR    = DEFAULT_LED_ADDR,
  parameter int                LED_W       = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_PORTS-1:0]        i_req_valid,
  input  logic [NUM_PORTS-1:0]        i_req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] i_req_wdata,
  output logic [NUM_PORTS-1:0]        o_req_ready,
  output logic [NUM_PORTS-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]           o_rsp_rdata,
  output logic                        o_ram_read_en,
  output logic                        o_ram_write_en,
  output logic [ADDR_W-1:0]           o_ram_address,
  output logic [DATA_W-1:0]           o_ram_data_write,
  input  logic [DATA_W-1:0]           i_ram_data_read,
  output logic [LED_W-1:0]            o_led
);

  localparam int IW = idx_w(NUM_PORTS);
  localparam int CW = $clog2(RAM_LATENCY) + 1;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_wdata;
  assign w_addr  = i_req_addr;
  assign w_wdata = i_req_wdata;

  bus_state_e            r_state, w_next;
  logic [IW-1:0]         r_port, w_gidx;
  logic [NUM_PORTS-1:0]  w_gnt;
  logic                  w_idle, w_take, w_gmmio;
  logic                  r_write, r_mmio;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata, w_led_ext;
  logic [LED_W-1:0]      r_mmio_wdata, r_led;
  logic [CW-1:0]         r_cnt;

  assign w_idle  = (r_state == ST_IDLE) && !i_rst;
  assign w_take  = |w_gnt;
  assign w_gmmio = (w_addr[w_gidx] == LED_ADDR);

  core_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (i_req_valid),
    .i_en  (w_idle),
    .i_adv (w_take),
    .o_gnt (w_gnt),
    .o_idx (w_gidx)
  );

  always_comb begin
    w_led_ext              = '0;
    w_led_ext[LED_W-1:0]   = r_led;
  end

  // Next state and all strobes; strobes are gated by reset so an aborted
  // transaction never shows a response or RAM access.
  always_comb begin
    w_next         = r_state;
    o_req_ready    = w_gnt;
    o_rsp_valid    = '0;
    o_rsp_rdata    = '0;
    o_ram_read_en  = 1'b0;
    o_ram_write_en = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_take) w_next = w_gmmio ? ST_RESP : ST_ISSUE;
      ST_ISSUE: begin
        w_next         = (RAM_LATENCY == 1) ? ST_RESP : ST_WAIT;
        o_ram_read_en  = !r_write && !i_rst;
        o_ram_write_en = r_write && !i_rst;
      end
      ST_WAIT:  if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: begin
        w_next = ST_IDLE;
        if (!i_rst) begin
          o_rsp_valid = NUM_PORTS'(1) << r_port;
          if (!r_write) o_rsp_rdata = r_mmio ? w_led_ext : i_ram_data_read;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_port       <= '0;
      r_write      <= 1'b0;
      r_mmio       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mmio_wdata <= '0;
      r_led        <= '0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_port  <= w_gidx;
        r_write <= i_req_write[w_gidx];
        r_mmio  <= w_gmmio;
        // RAM-facing address/data only move for RAM transactions.
        if (w_gmmio) r_mmio_wdata <= w_wdata[w_gidx][LED_W-1:0];
        else begin
          r_addr  <= w_addr[w_gidx];
          r_wdata <= w_wdata[w_gidx];
        end
      end
      if (r_state == ST_ISSUE)
        r_cnt <= (RAM_LATENCY > 1) ? CW'(RAM_LATENCY - 2) : '0;
      else if (r_state == ST_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (r_state == ST_RESP && r_mmio && r_write)
        r_led <= r_mmio_wdata;
    end
  end

  assign o_ram_address    = r_addr;
  assign o_ram_data_write = r_wdata;
  assign o_led            = r_led;

endmodule

// File: tb/tb_core_mem_fabric.sv
// Directed bench: fabric A uses RAM_LATENCY=1, fabric B RAM_LATENCY=3; both
// share clock and reset and each has its own simple RAM model.
module tb_core_mem_fabric;

  localparam logic [31:0] LED = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_run = 0;
  int          n_fail = 0;

  logic [1:0]  a_valid = '0, a_write = '0, a_ready, a_rsp;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata, a_raddr, a_rwd, a_rrd;
  logic        a_rre, a_rwe;
  logic [7:0]  a_led;

  logic [1:0]  b_valid = '0, b_write = '0, b_ready, b_rsp;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic [31:0] b_rdata, b_raddr, b_rwd, b_rrd, b_p0, b_p1, b_p2;
  logic        b_rre, b_rwe;
  logic [7:0]  b_led;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];

  always #5 clk = ~clk;

  core_mem_fabric #(.NUM_PORTS(2), .RAM_LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(a_valid), .i_req_write(a_write),
    .i_req_addr(a_addr), .i_req_wdata(a_wdata), .o_req_ready(a_ready),
    .o_rsp_valid(a_rsp), .o_rsp_rdata(a_rdata), .o_ram_read_en(a_rre),
    .o_ram_write_en(a_rwe), .o_ram_address(a_raddr), .o_ram_data_write(a_rwd),
    .i_ram_data_read(a_rrd), .o_led(a_led));

  core_mem_fabric #(.NUM_PORTS(2), .RAM_LATENCY(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(b_valid), .i_req_write(b_write),
    .i_req_addr(b_addr), .i_req_wdata(b_wdata), .o_req_ready(b_ready),
    .o_rsp_valid(b_rsp), .o_rsp_rdata(b_rdata), .o_ram_read_en(b_rre),
    .o_ram_write_en(b_rwe), .o_ram_address(b_raddr), .o_ram_data_write(b_rwd),
    .i_ram_data_read(b_rrd), .o_led(b_led));

  // RAM models: contents preloaded while reset is high.
  always @(posedge clk) begin
    if (rst) begin
      mem_a[8'h04] <= 32'hDEADBEEF;
      mem_a[8'h40] <= 32'h0000_1111;
      mem_a[8'h80] <= 32'h0000_2222;
    end else if (a_rwe) mem_a[a_raddr[9:2]] <= a_rwd;
    if (a_rre) a_rrd <= mem_a[a_raddr[9:2]];
  end

  always @(posedge clk) begin
    if (rst) mem_b[8'h10] <= 32'hCAFEF00D;
    else if (b_rwe) mem_b[b_raddr[9:2]] <= b_rwd;
    if (b_rre) b_p0 <= mem_b[b_raddr[9:2]];
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_rrd = b_p2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic a_set(input int p, input logic v, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd);
    a_valid[p] = v; a_write[p] = w; a_addr[p*32 +: 32] = ad; a_wdata[p*32 +: 32] = wd;
  endtask

  task automatic b_set(input int p, input logic v, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd);
    b_valid[p] = v; b_write[p] = w; b_addr[p*32 +: 32] = ad; b_wdata[p*32 +: 32] = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset: a request presented during reset is not accepted
    a_set(0, 1, 0, 32'h10, 0);
    mid(); chk("rst_ready", a_ready, 2'b00);
    nxt(); a_set(0, 0, 0, 0, 0);
    mid();
    chk("rst_rsp", a_rsp, 2'b00);   chk("rst_rre", a_rre, 1'b0);
    chk("rst_rwe", a_rwe, 1'b0);    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_led", a_led, 8'h00);   chk("rst_b_rsp", b_rsp, 2'b00);
    nxt(); rst = 1'b0;
    nxt();

    // 1: port0 read, latency 1
    a_set(0, 1, 0, 32'h10, 0);
    mid(); chk("t1_ready", a_ready, 2'b01);
    nxt(); a_set(0, 0, 0, 0, 0);
    mid(); chk("t1_rre", a_rre, 1'b1); chk("t1_raddr", a_raddr, 32'h10);
    chk("t1_rsp_early", a_rsp, 2'b00);
    nxt();
    mid(); chk("t1_rsp", a_rsp, 2'b01); chk("t1_rdata", a_rdata, 32'hDEADBEEF);
    chk("t1_rre_low", a_rre, 1'b0);
    nxt();

    // 6: RAM write then read back
    a_set(0, 1, 1, 32'h20, 32'h12345678);
    mid(); chk("t6w_ready", a_ready, 2'b01);
    nxt(); a_set(0, 0, 0, 0, 0);
    mid(); chk("t6w_rwe", a_rwe, 1'b1); chk("t6w_rre", a_rre, 1'b0);
    chk("t6w_data", a_rwd, 32'h12345678); chk("t6w_addr", a_raddr, 32'h20);
    nxt();
    mid(); chk("t6w_rsp", a_rsp, 2'b01); chk("t6w_rdata", a_rdata, 32'h0);
    chk("t6w_rwe_low", a_rwe, 1'b0);
    nxt();
    a_set(0, 1, 0, 32'h20, 0);
    mid(); chk("t6r_ready", a_ready, 2'b01);
    nxt(); a_set(0, 0, 0, 0, 0);
    mid(); chk("t6r_rre", a_rre, 1'b1);
    nxt();
    mid(); chk("t6r_rsp", a_rsp, 2'b01); chk("t6r_rdata", a_rdata, 32'h12345678);
    nxt();

    // 3: MMIO LED write and read by port1
    a_set(1, 1, 1, LED, 32'h0000_00A5);
    mid(); chk("t3w_ready", a_ready, 2'b10);
    nxt(); a_set(1, 0, 0, 0, 0);
    mid(); chk("t3w_rsp", a_rsp, 2'b10); chk("t3w_rre", a_rre, 1'b0);
    chk("t3w_rwe", a_rwe, 1'b0); chk("t3w_led_old", a_led, 8'h00);
    chk("t3w_raddr_hold", a_raddr, 32'h20);
    nxt();
    a_set(1, 1, 0, LED, 0);
    mid(); chk("t3_led", a_led, 8'hA5); chk("t3r_ready", a_ready, 2'b10);
    nxt(); a_set(1, 0, 0, 0, 0);
    mid(); chk("t3r_rsp", a_rsp, 2'b10); chk("t3r_rdata", a_rdata, 32'h0000_00A5);
    chk("t3r_rre", a_rre, 1'b0);
    nxt();

    // 2: both ports continuously valid -> alternating grants
    a_set(0, 1, 0, 32'h100, 0);
    a_set(1, 1, 0, 32'h200, 0);
    for (int i = 0; i < 4; i++) begin
      mid(); chk($sformatf("t2_gnt%0d", i), a_ready, (i % 2) ? 2'b10 : 2'b01);
      nxt();
      mid(); chk($sformatf("t2_busy%0d", i), a_ready, 2'b00);
      chk($sformatf("t2_addr%0d", i), a_raddr, (i % 2) ? 32'h200 : 32'h100);
      nxt();
      if (i == 3) begin a_set(0, 0, 0, 0, 0); a_set(1, 0, 0, 0, 0); end
      mid(); chk($sformatf("t2_rsp%0d", i), a_rsp, (i % 2) ? 2'b10 : 2'b01);
      chk($sformatf("t2_rdata%0d", i), a_rdata, (i % 2) ? 32'h2222 : 32'h1111);
      nxt();
    end

    // 4: latency 3, port1 read, requester keeps valid high throughout
    b_set(1, 1, 0, 32'h40, 0);
    mid(); chk("t4_ready", b_ready, 2'b10);
    nxt();
    mid(); chk("t4_rre", b_rre, 1'b1); chk("t4_ready1", b_ready, 2'b00);
    chk("t4_raddr", b_raddr, 32'h40);
    nxt();
    mid(); chk("t4_rre2", b_rre, 1'b0); chk("t4_ready2", b_ready, 2'b00);
    chk("t4_rsp2", b_rsp, 2'b00);
    nxt();
    mid(); chk("t4_rre3", b_rre, 1'b0); chk("t4_ready3", b_ready, 2'b00);
    chk("t4_rsp3", b_rsp, 2'b00);
    nxt();
    mid(); chk("t4_rsp", b_rsp, 2'b10); chk("t4_rdata", b_rdata, 32'hCAFEF00D);
    chk("t4_ready4", b_ready, 2'b00);
    b_set(1, 0, 0, 0, 0);
    nxt();
    mid(); chk("t4_idle_rsp", b_rsp, 2'b00);
    nxt();

    // 5: reset while in WAIT aborts the read and clears pointer and LED
    b_set(0, 1, 0, 32'h40, 0);
    mid(); chk("t5_ready", b_ready, 2'b01);
    nxt(); b_set(0, 0, 0, 0, 0);
    mid(); chk("t5_rre", b_rre, 1'b1);
    nxt(); rst = 1'b1;
    mid(); chk("t5_rst_rsp", b_rsp, 2'b00);
    nxt(); rst = 1'b0;
    mid(); chk("t5_rre_low", b_rre, 1'b0); chk("t5_led", a_led, 8'h00);
    for (int i = 0; i < 4; i++) begin
      mid(); chk($sformatf("t5_no_rsp%0d", i), b_rsp, 2'b00);
      nxt();
    end
    b_set(0, 1, 0, 32'h40, 0);
    b_set(1, 1, 0, 32'h10, 0);
    mid(); chk("t5_tie", b_ready, 2'b01);
    nxt(); b_set(0, 0, 0, 0, 0); b_set(1, 0, 0, 0, 0);
    mid(); chk("t5_rre2", b_rre, 1'b1);
    nxt(); nxt(); nxt();
    mid(); chk("t5_rsp", b_rsp, 2'b01); chk("t5_rdata", b_rdata, 32'hCAFEF00D);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
